// File: rtl/module_teclado_1.sv
// rtl/module_teclado_1.sv - 4x4 keypad operand capture: sync, debounce, decode, two-operand entry FSM
// Produces two binary operands (0..99) with sticky confirmation flags.
module module_teclado_1 #(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] row,
  input  logic [3:0] column,
  input  logic       key_out,
  output logic [7:0] first_num,
  output logic [7:0] second_num,
  output logic       listo_1,
  output logic       listo_2,
  output logic       listo
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {ENTER1, ENTER2, DONE} state_t;

  state_t        state;
  logic          key_s1, key_s2;
  logic          pressed;
  logic [CW-1:0] deb_cnt;
  logic          key_evt;
  logic [3:0]    row_q, col_q;
  logic [1:0]    digit_cnt;

  // {valid, index} for a code with exactly one bit low
  function automatic logic [2:0] decode_low(input logic [3:0] code);
    case (code)
      4'b1110: decode_low = 3'b100;
      4'b1101: decode_low = 3'b101;
      4'b1011: decode_low = 3'b110;
      4'b0111: decode_low = 3'b111;
      default: decode_low = 3'b000;
    endcase
  endfunction

  // The tracker counts the level opposite to its current state; a full run flips it.
  always_ff @(posedge clk) begin
    if (rst) begin
      key_s1  <= 1'b1;
      key_s2  <= 1'b1;
      pressed <= 1'b0;
      deb_cnt <= '0;
      key_evt <= 1'b0;
      row_q   <= 4'hf;
      col_q   <= 4'hf;
    end else begin
      key_s1  <= key_out;
      key_s2  <= key_s1;
      key_evt <= 1'b0;
      if (key_s2 == pressed) begin
        if (deb_cnt == CNT_LAST) begin
          deb_cnt <= '0;
          pressed <= ~pressed;
          if (!pressed) begin
            key_evt <= 1'b1;
            row_q   <= row;
            col_q   <= column;
          end
        end else begin
          deb_cnt <= deb_cnt + 1'b1;
        end
      end else begin
        deb_cnt <= '0;
      end
    end
  end

  logic [2:0] rd, cd;
  logic       key_valid, is_letter, is_star, is_hash;
  logic [3:0] digit;
  logic [7:0] cur_num, next_num;

  always_comb begin
    rd        = decode_low(row_q);
    cd        = decode_low(col_q);
    key_valid = key_evt & rd[2] & cd[2];
    is_letter = (cd[1:0] == 2'd3);
    is_star   = (rd[1:0] == 2'd3) && (cd[1:0] == 2'd0);
    is_hash   = (rd[1:0] == 2'd3) && (cd[1:0] == 2'd2);
    digit     = (rd[1:0] == 2'd3) ? 4'd0
              : ({2'b00, rd[1:0]} * 4'd3 + {2'b00, cd[1:0]} + 4'd1);
    cur_num   = (state == ENTER1) ? first_num : second_num;
    next_num  = cur_num * 8'd10 + {4'b0000, digit};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ENTER1;
      first_num  <= 8'd0;
      second_num <= 8'd0;
      listo_1    <= 1'b0;
      listo_2    <= 1'b0;
      listo      <= 1'b0;
      digit_cnt  <= 2'd0;
    end else if (key_valid && state != DONE) begin
      if (is_letter) begin
        digit_cnt <= 2'd0;
        if (state == ENTER1) begin
          listo_1 <= 1'b1;
          state   <= ENTER2;
        end else begin
          listo_2 <= 1'b1;
          listo   <= 1'b1;
          state   <= DONE;
        end
      end else if (is_star) begin
        digit_cnt <= 2'd0;
        if (state == ENTER1) first_num <= 8'd0;
        else                 second_num <= 8'd0;
      end else if (!is_hash && digit_cnt < 2'd2) begin
        digit_cnt <= digit_cnt + 2'd1;
        if (state == ENTER1) first_num <= next_num;
        else                 second_num <= next_num;
      end
    end
  end

endmodule

// File: tb/tb_module_teclado_1.sv
// tb/tb_module_teclado_1.sv - directed and randomized keypad sequences against an operand-entry model
module tb_module_teclado_1;

  localparam int DEB = 16;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] row, column;
  logic       key_out;
  logic [7:0] first_num, second_num;
  logic       listo_1, listo_2, listo;

  int n_assert = 0;
  int n_fail   = 0;

  // Model: which operand is being typed (0, 1, or 2 = finished), digits so far, values.
  int m_phase, m_dig, m_first, m_second;
  bit m_l1, m_l2;

  module_teclado_1 #(.DEBOUNCE_CYCLES(DEB)) dut (
    .clk(clk), .rst(rst), .row(row), .column(column), .key_out(key_out),
    .first_num(first_num), .second_num(second_num),
    .listo_1(listo_1), .listo_2(listo_2), .listo(listo)
  );

  always #5 clk = ~clk;

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, "_first"},  32'(first_num),  32'(m_first));
    check({tag, "_second"}, 32'(second_num), 32'(m_second));
    check({tag, "_listo1"}, 32'(listo_1),    32'(m_l1));
    check({tag, "_listo2"}, 32'(listo_2),    32'(m_l2));
    check({tag, "_listo"},  32'(listo),      32'(m_phase == 2));
  endtask

  task automatic model_reset();
    m_phase = 0; m_dig = 0; m_first = 0; m_second = 0; m_l1 = 0; m_l2 = 0;
  endtask

  task automatic model_key(input logic [3:0] rc, input logic [3:0] cc);
    int r, c, d;
    logic [3:0] ri, ci;
    ri = ~rc; ci = ~cc;
    if ($countones(ri) != 1 || $countones(ci) != 1 || m_phase == 2) return;
    r = 0; c = 0;
    for (int i = 0; i < 4; i++) begin
      if (ri[i]) r = i;
      if (ci[i]) c = i;
    end
    if (c == 3) begin
      if (m_phase == 0) m_l1 = 1; else m_l2 = 1;
      m_phase++;
      m_dig = 0;
    end else if (r == 3 && c == 0) begin
      if (m_phase == 0) m_first = 0; else m_second = 0;
      m_dig = 0;
    end else if (!(r == 3 && c == 2) && m_dig < 2) begin
      d = (r == 3) ? 0 : r * 3 + c + 1;
      if (m_phase == 0) m_first = m_first * 10 + d;
      else              m_second = m_second * 10 + d;
      m_dig++;
    end
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    cyc(n);
    rst = 1'b0;
    model_reset();
  endtask

  task automatic press(input logic [3:0] rc, input logic [3:0] cc, input int hold, input int rel);
    row = rc; column = cc; key_out = 1'b0;
    if (hold > DEB) model_key(rc, cc);
    if (hold >= DEB + 5) begin
      cyc(DEB + 4);
      check_all("latency");
      cyc(hold - DEB - 4);
    end else begin
      cyc(hold);
    end
    key_out = 1'b1; row = 4'hf; column = 4'hf;
    cyc(rel);
    check_all("after_press");
  endtask

  // One-hot-low codes from row/column index
  function automatic logic [3:0] oh(input int i);
    logic [3:0] v;
    v = 4'b0001 << i;
    return ~v;
  endfunction

  task automatic key(input int r, input int c);
    press(oh(r), oh(c), 100, 100);
  endtask

  initial begin
    rst = 1'b1; row = 4'hf; column = 4'hf; key_out = 1'b1;
    model_reset();

    do_reset(200);
    check_all("reset");

    key(0, 0); key(0, 1); key(0, 3);
    check("op1_first", 32'(first_num), 32'd12);
    check("op1_listo1", 32'(listo_1), 32'd1);
    check("op1_listo2", 32'(listo_2), 32'd0);

    key(0, 2); key(1, 0);
    press(4'b1101, 4'b0111, 100, 100);
    check("op2_second", 32'(second_num), 32'd34);
    check("op2_listo", 32'(listo), 32'd1);
    key(1, 1);
    check_all("done_ignore");

    do_reset(3);
    press(oh(2), oh(0), 5, 100);
    check("short_press", 32'(first_num), 32'd0);
    row = oh(2); column = oh(0); key_out = 1'b0;
    model_key(oh(2), oh(0));
    cyc(150);
    key_out = 1'b1; cyc(3);
    key_out = 1'b0; cyc(147);
    key_out = 1'b1; row = 4'hf; column = 4'hf;
    cyc(100);
    check("glitch_once", 32'(first_num), 32'd7);
    check_all("glitch");

    do_reset(3);
    key(2, 2); key(2, 1); key(2, 0);
    check("two_digit_max", 32'(first_num), 32'd98);
    key(3, 0);
    check("star_clear", 32'(first_num), 32'd0);
    key(1, 1); key(0, 3);
    check("after_star_first", 32'(first_num), 32'd5);
    check("after_star_listo1", 32'(listo_1), 32'd1);

    do_reset(3);
    key(0, 3);
    check_all("empty_operand");
    do_reset(3);
    key(1, 0); key(0, 3); key(1, 2);
    check("enter2_first", 32'(first_num), 32'd4);
    do_reset(1);
    check_all("mid_reset");
    press(4'b1100, 4'b1110, 100, 100);
    check_all("invalid_code");
    key(0, 2);
    check("post_reset_enter1", 32'(first_num), 32'd3);

    do_reset(3);
    for (int i = 0; i < 40; i++) begin
      logic [3:0] rc, cc;
      int hold;
      rc = oh($urandom_range(0, 3));
      cc = oh($urandom_range(0, 3));
      if ($urandom_range(0, 7) == 0) rc = 4'($urandom_range(0, 15));
      hold = ($urandom_range(0, 4) == 0) ? $urandom_range(1, 12) : $urandom_range(21, 60);
      press(rc, cc, hold, $urandom_range(20, 40));
      if (m_phase == 2 && $urandom_range(0, 2) == 0) begin
        do_reset($urandom_range(1, 4));
        check_all("rand_reset");
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
